flick_scheduler: RTL and testbench

- Shares one bound_flasher instance among NUM_REQ flick requesters using round-robin arbitration.
- Generates a clean flick pulse of fixed length for the selected requester.
- Monitors the flasher's LED bus to detect when a sequence starts and when it ends.
- Enforces a cooldown gap between sequences. Sits between the request sources and bound_flasher's flick input.

---
 rtl/flick_pkg.sv | 29 ++
 rtl/flick_scheduler_rr_pick.sv | 32 +++
 rtl/flick_scheduler.sv | 123 ++++++++++++
 tb/tb_flick_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/flick_pkg.sv
// Shared state encoding, default parameters and counter sizing for flick_scheduler.
package flick_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PULSE    = 3'd1,
      WAIT_ACT = 3'd2,
      RUN      = 3'd3,
      GAP      = 3'd4
   } state_e;

   localparam int unsigned DEF_NUM_REQ   = 4;
   localparam int unsigned DEF_LED_W     = 16;
   localparam int unsigned DEF_FLICK_LEN = 2;
   localparam int unsigned DEF_GAP_LEN   = 4;
   localparam int unsigned DEF_TIMEOUT   = 8;

   // Width of one down-counter able to hold the largest of the three phase lengths.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/flick_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from ptr_i+1.
module rr_pick
   import flick_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   localparam int unsigned IW     = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic [IW-1:0]      index_o,
   output logic               valid_o
);

   logic [IW-1:0] idx;

   always_comb begin
      onehot_o = '0;
      index_o  = '0;
      valid_o  = 1'b0;
      idx      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IW'((32'(ptr_i) + i) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            valid_o = 1'b1;
            index_o = idx;
         end
      end
      onehot_o[index_o] = valid_o;
   end

endmodule

// File: rtl/flick_scheduler.sv
// Round-robin sharing of one bound_flasher among NUM_REQ requesters with pulse, LED watch and cooldown.
// Define FLICK_KICK_EN to let the owner drive flick_out (one cycle late) while the flasher runs.
module flick_scheduler
   import flick_pkg::*;
#(
   parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
   parameter int unsigned LED_W     = DEF_LED_W,
   parameter int unsigned FLICK_LEN = DEF_FLICK_LEN,
   parameter int unsigned GAP_LEN   = DEF_GAP_LEN,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [LED_W-1:0]           led_in,
   output logic                       flick_out,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       err
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = cnt_width(FLICK_LEN, GAP_LEN, TIMEOUT);

   // Counters hold "cycles remaining minus one" so the phase ends when they read zero.
   localparam logic [CW-1:0] FLICK_RELOAD   = CW'(FLICK_LEN - 1);
   localparam logic [CW-1:0] GAP_RELOAD     = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] TIMEOUT_RELOAD = CW'(TIMEOUT - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [IW-1:0] ptr_q;

   logic [NUM_REQ-1:0] pick_onehot;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .index_o  (pick_idx),
      .valid_o  (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= IW'(NUM_REQ - 1);
         flick_out <= 1'b0;
         gnt       <= '0;
         owner     <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         gnt <= '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  gnt       <= pick_onehot;
                  owner     <= pick_idx;
                  ptr_q     <= pick_idx;
                  flick_out <= 1'b1;
                  busy      <= 1'b1;
                  cnt_q     <= FLICK_RELOAD;
                  state_q   <= PULSE;
               end
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  flick_out <= 1'b0;
                  cnt_q     <= TIMEOUT_RELOAD;
                  state_q   <= WAIT_ACT;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            WAIT_ACT: begin
               if (led_in != '0) begin
                  cnt_q   <= '0;
                  state_q <= RUN;
               end else if (cnt_q == '0) begin
                  err     <= 1'b1;
                  cnt_q   <= GAP_RELOAD;
                  state_q <= GAP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            RUN: begin
               if (led_in == '0) begin
                  flick_out <= 1'b0;
                  cnt_q     <= GAP_RELOAD;
                  state_q   <= GAP;
               end else begin
`ifdef FLICK_KICK_EN
                  flick_out <= req[owner];
`else
                  flick_out <= 1'b0;
`endif
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               flick_out <= 1'b0;
               busy      <= 1'b0;
               cnt_q     <= '0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flick_scheduler.sv
// Randomized scoreboard bench for flick_scheduler: grant order, grant spacing, err and reset behaviour.
module tb_flick_scheduler;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned LED_W     = 16;
   localparam int unsigned FLICK_LEN = 2;
   localparam int unsigned GAP_LEN   = 4;
   localparam int unsigned TIMEOUT   = 8;
   localparam int unsigned IW        = $clog2(NUM_REQ);
   localparam int          NSEQ      = 40;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req;
   logic [LED_W-1:0]   led_in;
   logic               flick_out;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      owner;
   logic               busy;
   logic               err;

   always #5 clk = ~clk;

   flick_scheduler #(
      .NUM_REQ(NUM_REQ), .LED_W(LED_W), .FLICK_LEN(FLICK_LEN),
      .GAP_LEN(GAP_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .led_in(led_in),
      .flick_out(flick_out), .gnt(gnt), .owner(owner), .busy(busy), .err(err)
   );

   typedef struct {
      int idx;
      int interval;   // 0 = spacing not checked
      bit err;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   int   cyc    = 0;
   int   last_g = 0;
   int   fl_run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first requester above the last winner, wrapping.
   function automatic int rr_next(input int last, input logic [NUM_REQ-1:0] m);
      for (int i = 1; i <= int'(NUM_REQ); i++)
         if (m[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
      return -1;
   endfunction

   // Monitor: every presented grant is compared against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (mon_en) begin
         if (gnt != '0) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_grant: got gnt=%0h expected no grant", gnt);
            end else begin
               e = q.pop_front();
               chk("gnt_onehot", 32'(gnt), 32'(1) << e.idx);
               chk("owner", 32'(owner), 32'(e.idx));
               chk("flick_at_grant", 32'(flick_out), 32'd1);
               chk("busy_at_grant", 32'(busy), 32'd1);
               chk("err_sticky", 32'(err), 32'(e.err));
               if (e.interval != 0) chk("grant_spacing", 32'(cyc - last_g), 32'(e.interval));
            end
            last_g = cyc;
         end
`ifndef FLICK_KICK_EN
         if (flick_out) fl_run++;
         else if (fl_run != 0) begin
            chk("flick_len", 32'(fl_run), 32'(FLICK_LEN));
            fl_run = 0;
         end
`endif
      end
   end

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            ok = 1'b1;
            return;
         end
      end
      checks++; errors++;
      $display("FAIL wait_gnt: no grant within 80 cycles, expected one");
   endtask

   initial begin
      bit                 ok;
      bit                 model_err;
      int                 model_last;
      int                 d, l, nxt, own;
      logic [NUM_REQ-1:0] m;

      rst    = 1'b1;
      req    = '1;
      led_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_flick", 32'(flick_out), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      model_err  = 1'b0;
      model_last = 0;
      q.push_back('{idx: 0, interval: 0, err: 1'b0});
      mon_en = 1'b1;
      rst    = 1'b0;

      for (int k = 0; k < NSEQ; k++) begin
         wait_gnt(ok);
         if (!ok) break;
         if (k == NSEQ - 1) break;
         // Plan this sequence's LED response and the next request mask.
         if (k < 5) begin
            d = 0; l = 3; m = '1;
         end else begin
            d = int'($urandom_range(0, TIMEOUT + 2));
            l = int'($urandom_range(1, 5));
            m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         end
         req = m;
         if (d >= int'(TIMEOUT)) model_err = 1'b1;
         nxt        = rr_next(model_last, m);
         model_last = nxt;
         q.push_back('{idx: nxt,
                       interval: (d >= int'(TIMEOUT)) ? int'(FLICK_LEN + TIMEOUT + GAP_LEN + 1)
                                                     : int'(FLICK_LEN) + d + 1 + l + int'(GAP_LEN) + 1,
                       err: model_err});
         repeat (FLICK_LEN) @(negedge clk);
         if (d < int'(TIMEOUT)) begin
            repeat (d) @(negedge clk);
            led_in = LED_W'($urandom_range(1, (1 << LED_W) - 1));
            repeat (l) @(negedge clk);
            led_in = '0;
         end
      end

      // Reset while the flasher is running.
      own = model_last;
      repeat (FLICK_LEN) @(negedge clk);
      led_in = 16'h00ff;
      @(negedge clk);
      req = NUM_REQ'(1) << own;
      @(negedge clk);
`ifdef FLICK_KICK_EN
      chk("kick_follow", 32'(flick_out), 32'd1);
`else
      chk("run_flick_low", 32'(flick_out), 32'd0);
`endif
      chk("run_busy", 32'(busy), 32'd1);
      mon_en = 1'b0;
      rst    = 1'b1;
      led_in = '0;
      req    = '1;
      @(negedge clk);
      chk("midrst_flick", 32'(flick_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_owner", 32'(owner), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);
      q.delete();
      q.push_back('{idx: 0, interval: 0, err: 1'b0});
      fl_run = 0;
      mon_en = 1'b1;
      rst    = 1'b0;
      wait_gnt(ok);
      @(negedge clk);
      chk("post_rst_pending", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
